// File: rtl/fifo_rd_stream.sv
// Drains a FIFO read port into a valid/ready packet stream through a 2-entry skid buffer.
// Packets are PKTLEN words; enable only gates the start of a new packet.
module fifo_rd_stream #(
    parameter int DATASIZE = 8,
    parameter int PKTLEN   = 16
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                rempty,
    input  logic [DATASIZE-1:0] rdata,
    output logic                rinc,
    input  logic                enable,
    output logic                m_valid,
    output logic [DATASIZE-1:0] m_data,
    output logic                m_last,
    input  logic                m_ready,
    output logic [15:0]         pkt_count,
    output logic                busy
);

    localparam logic [1:0]  OCC_EMPTY = 2'd0;
    localparam logic [1:0]  OCC_ONE   = 2'd1;
    localparam logic [1:0]  OCC_TWO   = 2'd2;
    localparam logic [15:0] LAST_IDX  = 16'(PKTLEN - 1);

    logic [1:0]          occ_reg, occ_next;
    logic [DATASIZE-1:0] head_reg, head_next;
    logic [DATASIZE-1:0] tail_reg, tail_next;
    logic [15:0]         pcnt_reg, pcnt_next;
    logic [15:0]         ocnt_reg, ocnt_next;
    logic [15:0]         pkt_count_reg, pkt_count_next;

    logic rd_ok;
    logic handshake;

    // rinc is masked by rrst so no pop is requested while the block is held in reset.
    always_comb begin
        rd_ok     = enable || (pcnt_reg != 16'd0);
        rinc      = rrst && rd_ok && !rempty && (occ_reg != OCC_TWO);
        m_valid   = (occ_reg != OCC_EMPTY);
        m_data    = head_reg;
        m_last    = m_valid && (ocnt_reg == LAST_IDX);
        handshake = m_valid && m_ready;
        busy      = m_valid || (pcnt_reg != 16'd0);
        pkt_count = pkt_count_reg;
    end

    // head_reg is always the oldest word; rdata is only captured when rinc is high.
    always_comb begin
        occ_next  = occ_reg;
        head_next = head_reg;
        tail_next = tail_reg;
        case (occ_reg)
            OCC_EMPTY: begin
                if (rinc) begin
                    head_next = rdata;
                    occ_next  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                case ({rinc, handshake})
                    2'b10: begin
                        tail_next = rdata;
                        occ_next  = OCC_TWO;
                    end
                    2'b01: occ_next = OCC_EMPTY;
                    2'b11: head_next = rdata;
                    default: ;
                endcase
            end
            OCC_TWO: begin
                if (handshake) begin
                    head_next = tail_reg;
                    occ_next  = OCC_ONE;
                end
            end
            default: occ_next = OCC_EMPTY;
        endcase
    end

    always_comb begin
        pcnt_next      = pcnt_reg;
        ocnt_next      = ocnt_reg;
        pkt_count_next = pkt_count_reg;
        if (rinc) begin
            pcnt_next = (pcnt_reg == LAST_IDX) ? 16'd0 : pcnt_reg + 16'd1;
        end
        if (handshake) begin
            ocnt_next = (ocnt_reg == LAST_IDX) ? 16'd0 : ocnt_reg + 16'd1;
            if (m_last) begin
                pkt_count_next = pkt_count_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            occ_reg       <= OCC_EMPTY;
            head_reg      <= '0;
            tail_reg      <= '0;
            pcnt_reg      <= 16'd0;
            ocnt_reg      <= 16'd0;
            pkt_count_reg <= 16'd0;
        end else begin
            occ_reg       <= occ_next;
            head_reg      <= head_next;
            tail_reg      <= tail_next;
            pcnt_reg      <= pcnt_next;
            ocnt_reg      <= ocnt_next;
            pkt_count_reg <= pkt_count_next;
        end
    end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter DATASIZE, default 8: FIFO word and stream data width in bits.
REQ-002 Parameter PKTLEN, default 16: words per packet; legal range 1..65535.
REQ-003 rclk  input  1: single clock, shared with the FIFO read domain; every flop is on its rising edge.
REQ-004 rrst  input  1: reset, asynchronous assert, active-low.
REQ-005 rempty  input  1: FIFO empty flag; rdata is valid whenever rempty=0.
REQ-006 rdata  input  DATASIZE: FIFO head word; combinational from the FIFO read address.
REQ-007 rinc  output  1: FIFO pop strobe; the head word is consumed on the rclk edge where rinc=1.
REQ-008 enable  input  1: streaming enable; only sampled at packet boundaries (see REQ-016).
REQ-009 m_valid  output  1: output stream word valid.
REQ-010 m_data  output  DATASIZE: output stream data.
REQ-011 m_last  output  1: marks the final word of a packet.
REQ-012 m_ready  input  1: downstream accept; handshake occurs on an edge with m_valid=1 and m_ready=1.
REQ-013 pkt_count  output  16: number of completed packets, modulo 2^16.
REQ-014 busy  output  1: a packet is partially read or the buffer holds data.

Function
REQ-015 Buffer: 2-entry registered FIFO with occupancy state EMPTY/ONE/TWO; m_data is always the oldest entry; m_valid = (occupancy != EMPTY).
REQ-016 Pop counter pcnt (0..PKTLEN-1): increments on every rinc and wraps PKTLEN-1 -> 0.
- Read permission rd_ok = enable OR (pcnt != 0), so a started packet is always read to completion.
REQ-017 rinc = rd_ok AND NOT rempty AND (occupancy != TWO).
- rinc is combinational from registered state and inputs only; it SHALL NOT depend on m_ready.
REQ-018 Latency: a word popped on edge k is on m_data with m_valid=1 from edge k onward, i.e. the cycle after rinc.
REQ-019 Ordering: words appear on m_data in exact FIFO pop order; no loss, no duplication.
REQ-020 Occupancy transitions, applied on each edge:
- push only: +1.
- handshake only: -1.
- push and handshake together: unchanged, with the new word entering behind the remaining entry.
REQ-021 Throughput: with rempty=0, m_ready=1 and rd_ok=1 held, one word SHALL be transferred every cycle in steady state.
REQ-022 Output counter ocnt (0..PKTLEN-1): increments on each handshake and wraps at PKTLEN-1.
- m_last = m_valid AND (ocnt == PKTLEN-1).
- With PKTLEN=1, m_last=1 on every valid word.
REQ-023 pkt_count increments by 1 on each handshake with m_last=1, wrapping 65535 -> 0.
REQ-024 busy = (occupancy != EMPTY) OR (pcnt != 0).
REQ-025 m_valid=1 with m_ready=0: m_data and m_last SHALL hold stable until the handshake.
REQ-026 enable deasserted mid-packet: popping continues until pcnt wraps to 0; buffered words always drain regardless of enable.
REQ-027 rempty=1 mid-packet: rinc=0 and the block waits indefinitely; no timeout and no packet truncation.
REQ-028 X on rdata while rinc=0 SHALL NOT propagate into buffer state.

Reset
REQ-029 While rrst=0 the following SHALL hold:
- occupancy=EMPTY, pcnt=0, ocnt=0, pkt_count=0.
- m_valid=0, m_last=0, rinc=0, busy=0; m_data=0.
REQ-030 Reset asserted mid-packet discards buffered words and partial counts immediately (asynchronously).
REQ-031 The first rinc after release SHALL occur no earlier than the first rclk edge after rrst goes high.

Verification (DATASIZE=8, PKTLEN=4)
REQ-032 Streaming: FIFO holds 0x10..0x17, enable=1, m_ready=1.
- Response: 8 consecutive-cycle words 0x10..0x17.
- m_last on 0x13 and 0x17; pkt_count=2; busy=0 afterwards.
REQ-033 Backpressure: m_ready=0 for 5 cycles after the first word appears.
- Response: exactly 2 pops occur, then rinc=0.
- m_data holds 0x10; order preserved after m_ready=1.
REQ-034 Packet-boundary stop: enable drops after the 2nd pop.
- Response: exactly 4 words popped, last=0x13 with m_last=1.
- Then rinc=0 although the FIFO is non-empty; busy falls after the drain.
REQ-035 Underflow mid-packet: FIFO holds only 0x20,0x21; more words are written 10 cycles later.
- Response: rinc=0 while rempty=1, busy=1.
- The packet resumes with m_last on the 4th word.
REQ-036 Reset mid-packet: rrst=0 with occupancy=TWO and pcnt=2.
- Response: m_valid=0 and busy=0 immediately.
- pkt_count=0; the first packet after release starts with ocnt=0.
REQ-037 Wrap: pkt_count preloaded via 65535 completed packets, then one more packet.
- Response: pkt_count=0.
